tz80_core2: RTL and testbench
=============================

Name: tz80_core2

Overview:
- Second-generation Thumb Z80 core: multi-cycle, reduced-ISA Z80 subset on a single 8-bit memory port.
- Extends the first core (EX AF,AF' and LD rr,nn only) with EXX, 16-bit INC/DEC, 8-bit immediate loads, absolute/relative jumps, direct memory load/store and HALT.
- Reset vector and stack pointer reset value are parametrised.
- Sits between the system clock/reset and a memory with asynchronous read and synchronous write.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_SP, 16'hFFFF, SP value loaded on reset
HALT_EN, 1, 1: opcode 76h halts the core; 0: 76h executes as a 1T NOP

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
locked  in  1  clock-enable; low freezes all state and forces we=0
address  out  16  memory address: cursor when select=1, else pc
i_data  in  8  read data, valid in the same cycle as address (asynchronous read)
o_data  out  8  write data, registered
we  out  1  write strobe, registered; memory samples address/o_data on the next edge
m1  out  1  high while phase=0 (opcode fetch cycle)
halted  out  1  high while the core is halted

Behaviour:
- Reset (reset=1 at edge, overrides locked):
  - pc=RESET_PC, sp=RESET_SP; af, bc, de, hl and all prime registers = 0.
  - phase=0, select=0, we=0, o_data=0, halted=0, so m1=1 and address=RESET_PC.
  - Reset during any phase aborts the instruction; no partial register or memory update survives.
- locked=0: no state changes; we is driven 0 in that cycle; resumes exactly where it stopped.
- T1 (phase 0): opcode = i_data; ir<=i_data; pc<=pc+1. In later phases the decode uses ir.
- Only one T-state per enabled clock. All 16-bit arithmetic wraps modulo 2^16. No flags are modified by any instruction.
- Instructions, with T-states:
  - 00h NOP, 1T.
  - 08h EX AF,AF', 1T: swap af/af_prime.
  - D9h EXX, 1T: swap bc, de, hl with their primes.
  - 00rr0011 INC rr / 00rr1011 DEC rr, 1T; rr: 00=BC, 01=DE, 10=HL, 11=SP.
  - 00rr0001 LD rr,nn, 3T: T2 low byte, T3 high byte, pc+1 each.
  - 00ddd110 LD r,n, 2T; ddd: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 111 A.
  - 36h LD (HL),n, 3T:
    - T2: latch n, cursor<=hl, select<=1, o_data<=n, we<=1, pc+1.
    - T3: write occurs; select<=0, we<=0.
  - C3h JP nn, 3T: T3 pc<={i_data, lo}.
  - 18h JR e, 2T: pc <= (address of the byte after e) + sign_extend(e). JR FEh loops on itself.
  - 32h LD (nn),A, 4T:
    - T3: cursor<={i_data, lo}, select<=1, o_data<=A, we<=1.
    - T4: write; then select<=0, we<=0.
  - 3Ah LD A,(nn), 4T:
    - T3: cursor set, select<=1.
    - T4: A<=i_data; select<=0.
  - 76h HALT (HALT_EN=1), 1T: halted<=1.
    - pc is left pointing after HALT; no fetch or write while halted; address holds pc.
    - Only reset exits HALT.
  - Any other opcode: 1T NOP, pc+1.
- we is asserted for exactly one enabled cycle per store. If locked drops while we=1, the strobe is suppressed that cycle and reasserted when locked returns; the write completes exactly once.
- Fetch at pc=FFFFh: pc wraps to 0000h. Operand fetches wrap the same way.

Test Plan:
- Reset with RESET_PC=0100h, RESET_SP=FFFEh: after release, address=0100h, m1=1, we=0, halted=0.
- Program 3E 5A 32 00 80 76: exactly one write, address=8000h, o_data=5Ah; then halted=1 with address=0006h.
- 01 34 12 03 0B 0B, then LD A via C→A path (79h unsupported, so store C using 21 00 90 36 xx): BC=1233h. Checks INC/DEC by storing via LD A,C-free sequence (3E/32 after EXX swap check): EX AF and EXX round-trip restores A=5Ah, BC=1233h.
- JR: 18 FE loops at fixed pc for 10 cycles. 18 02 skips two bytes. C3 00 00 restarts at 0000h.
- Preload memory 8000h=A5h; 3A 00 80 32 01 80 writes A5h to 8001h in exactly 8 enabled cycles. Toggle locked low for 3 cycles mid-instruction: same result, still a single we pulse.
- Assert reset in T3 of LD (nn),A: no we pulse; execution restarts at RESET_PC. With HALT_EN=0, 76h advances pc by 1 and halted stays 0.

Source files
------------

// File: rtl/tz80_core2_if.sv
`default_nettype none
// =============================================================================
// tz80_core2_if : single 8-bit memory port of the tz80_core2 core
// Revision      : 1.0
// =============================================================================
interface tz80_core2_if;
  logic [15:0] address;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        we;
  logic        m1;
  logic        halted;

  modport master (
    output address, o_data, we, m1, halted,
    input  i_data
  );

  modport slave (
    input  address, o_data, we, m1, halted,
    output i_data
  );
endinterface
`default_nettype wire

// File: rtl/tz80_core2.sv
`default_nettype none
// =============================================================================
// tz80_core2 : multi-cycle reduced-ISA Z80 subset core on one 8-bit memory port
// Revision   : 1.0
// =============================================================================
module tz80_core2 #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFF,
  parameter bit          HALT_EN  = 1'b1
) (
  input wire           clock,
  input wire           reset,
  input wire           locked,
  tz80_core2_if.master bus
);
  typedef enum logic [1:0] {
    PH_T1 = 2'd0,
    PH_T2 = 2'd1,
    PH_T3 = 2'd2,
    PH_T4 = 2'd3
  } phase_t;

  phase_t      phase, phase_n;
  logic [15:0] pc, pc_n, sp, sp_n;
  logic [15:0] af, af_n, bc, bc_n, de, de_n, hl, hl_n;
  logic [15:0] af_p, af_p_n, bc_p, bc_p_n, de_p, de_p_n, hl_p, hl_p_n;
  logic [15:0] cursor, cursor_n;
  logic [7:0]  ir, ir_n, lo, lo_n, wdata, wdata_n;
  logic        select, select_n, we_q, we_n, halt, halt_n;

  logic [7:0]  op;
  logic [15:0] rr_cur, rr_new;
  logic        rr_wr, r8_wr;

  // Opcode comes straight off the bus in T1, from ir afterwards
  assign op = (phase == PH_T1) ? bus.i_data : ir;

  always_comb begin
    rr_cur = bc;
    case (op[5:4])
      2'b00:   rr_cur = bc;
      2'b01:   rr_cur = de;
      2'b10:   rr_cur = hl;
      default: rr_cur = sp;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase  <= PH_T1;
      pc     <= RESET_PC;
      sp     <= RESET_SP;
      af     <= '0;
      bc     <= '0;
      de     <= '0;
      hl     <= '0;
      af_p   <= '0;
      bc_p   <= '0;
      de_p   <= '0;
      hl_p   <= '0;
      cursor <= '0;
      ir     <= '0;
      lo     <= '0;
      wdata  <= '0;
      select <= 1'b0;
      we_q   <= 1'b0;
      halt   <= 1'b0;
    end else if (locked) begin
      phase  <= phase_n;
      pc     <= pc_n;
      sp     <= sp_n;
      af     <= af_n;
      bc     <= bc_n;
      de     <= de_n;
      hl     <= hl_n;
      af_p   <= af_p_n;
      bc_p   <= bc_p_n;
      de_p   <= de_p_n;
      hl_p   <= hl_p_n;
      cursor <= cursor_n;
      ir     <= ir_n;
      lo     <= lo_n;
      wdata  <= wdata_n;
      select <= select_n;
      we_q   <= we_n;
      halt   <= halt_n;
    end
  end

  always_comb begin
    phase_n  = phase;
    pc_n     = pc;
    sp_n     = sp;
    af_n     = af;
    bc_n     = bc;
    de_n     = de;
    hl_n     = hl;
    af_p_n   = af_p;
    bc_p_n   = bc_p;
    de_p_n   = de_p;
    hl_p_n   = hl_p;
    cursor_n = cursor;
    ir_n     = ir;
    lo_n     = lo;
    wdata_n  = wdata;
    select_n = select;
    we_n     = we_q;
    halt_n   = halt;
    rr_wr    = 1'b0;
    rr_new   = rr_cur;
    r8_wr    = 1'b0;

    if (!halt) begin
      case (phase)
        PH_T1: begin
          ir_n = op;
          pc_n = pc + 16'd1;
          casez (op)
            8'h08: begin
              af_n   = af_p;
              af_p_n = af;
            end
            8'hD9: begin
              bc_n   = bc_p;
              bc_p_n = bc;
              de_n   = de_p;
              de_p_n = de;
              hl_n   = hl_p;
              hl_p_n = hl;
            end
            8'h76: halt_n = HALT_EN;
            8'b00??0011: begin
              rr_wr  = 1'b1;
              rr_new = rr_cur + 16'd1;
            end
            8'b00??1011: begin
              rr_wr  = 1'b1;
              rr_new = rr_cur - 16'd1;
            end
            8'b00??0001, 8'b00???110, 8'hC3, 8'h18, 8'h32, 8'h3A:
              phase_n = PH_T2;
            default: ;
          endcase
        end

        PH_T2: begin
          pc_n    = pc + 16'd1;
          phase_n = PH_T1;
          casez (op)
            8'h36: begin
              cursor_n = hl;
              select_n = 1'b1;
              wdata_n  = bus.i_data;
              we_n     = 1'b1;
              phase_n  = PH_T3;
            end
            // pc already addresses e here, so +1 lands on the byte after it
            8'h18: pc_n = pc + 16'd1 + {{8{bus.i_data[7]}}, bus.i_data};
            8'b00??0001: begin
              rr_wr   = 1'b1;
              rr_new  = {rr_cur[15:8], bus.i_data};
              phase_n = PH_T3;
            end
            8'b00???110: r8_wr = 1'b1;
            8'hC3, 8'h32, 8'h3A: begin
              lo_n    = bus.i_data;
              phase_n = PH_T3;
            end
            default: ;
          endcase
        end

        PH_T3: begin
          phase_n = PH_T1;
          casez (op)
            8'h36: begin
              select_n = 1'b0;
              we_n     = 1'b0;
            end
            8'hC3: pc_n = {bus.i_data, lo};
            8'h32: begin
              cursor_n = {bus.i_data, lo};
              select_n = 1'b1;
              wdata_n  = af[15:8];
              we_n     = 1'b1;
              pc_n     = pc + 16'd1;
              phase_n  = PH_T4;
            end
            8'h3A: begin
              cursor_n = {bus.i_data, lo};
              select_n = 1'b1;
              pc_n     = pc + 16'd1;
              phase_n  = PH_T4;
            end
            8'b00??0001: begin
              rr_wr  = 1'b1;
              rr_new = {bus.i_data, rr_cur[7:0]};
              pc_n   = pc + 16'd1;
            end
            default: ;
          endcase
        end

        PH_T4: begin
          phase_n  = PH_T1;
          select_n = 1'b0;
          we_n     = 1'b0;
          if (op == 8'h3A) af_n[15:8] = bus.i_data;
        end
      endcase
    end

    if (rr_wr) begin
      case (op[5:4])
        2'b00:   bc_n = rr_new;
        2'b01:   de_n = rr_new;
        2'b10:   hl_n = rr_new;
        default: sp_n = rr_new;
      endcase
    end

    if (r8_wr) begin
      case (op[5:3])
        3'b000:  bc_n[15:8] = bus.i_data;
        3'b001:  bc_n[7:0]  = bus.i_data;
        3'b010:  de_n[15:8] = bus.i_data;
        3'b011:  de_n[7:0]  = bus.i_data;
        3'b100:  hl_n[15:8] = bus.i_data;
        3'b101:  hl_n[7:0]  = bus.i_data;
        3'b111:  af_n[15:8] = bus.i_data;
        default: ;
      endcase
    end
  end

  assign bus.address = select ? cursor : pc;
  assign bus.o_data  = wdata;
  // A stalled store keeps we_q set, so the strobe simply reappears on resume
  assign bus.we      = we_q & locked;
  assign bus.m1      = (phase == PH_T1);
  assign bus.halted  = halt;

endmodule
`default_nettype wire

// File: tb/tb_tz80_core2.sv
`default_nettype none
// =============================================================================
// tb_tz80_core2 : directed self-checking bench for tz80_core2
// Revision      : 1.0
// =============================================================================
module tb_tz80_core2;
  logic clock = 1'b0;
  logic reset, reset2, locked;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  tz80_core2_if bus1();
  tz80_core2_if bus2();

  tz80_core2 #(.RESET_PC(16'h0100), .RESET_SP(16'hFFFE), .HALT_EN(1'b1)) dut (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .bus    (bus1)
  );

  tz80_core2 #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFF), .HALT_EN(1'b0)) dut_nohalt (
    .clock  (clock),
    .reset  (reset2),
    .locked (1'b1),
    .bus    (bus2)
  );

  logic [7:0]  mem [0:65535];
  logic        ld_en, wr_clr;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  int          wr_count;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  assign bus1.i_data = mem[bus1.address];
  assign bus2.i_data = 8'h76;

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus1.we) mem[bus1.address] <= bus1.o_data;
    if (wr_clr) begin
      wr_count <= 0;
    end else if (bus1.we) begin
      wr_count <= wr_count + 1;
      wr_addr  <= bus1.address;
      wr_data  <= bus1.o_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Bytes are right-aligned in the vector, first byte most significant
  task automatic load(input logic [15:0] a, input logic [255:0] bytes, input int n);
    for (int i = 0; i < n; i++) poke(a + 16'(i), bytes[(n-1-i)*8 +: 8]);
  endtask

  task automatic hold_reset();
    reset  = 1'b1;
    locked = 1'b1;
    wr_clr = 1'b1;
    tick();
    wr_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1; locked = 1'b1;
    ld_en = 1'b0; wr_clr = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    hold_reset();
    reset = 1'b0;
    check("rst_address", bus1.address, 32'h0100);
    check("rst_m1",      bus1.m1,      32'h1);
    check("rst_we",      bus1.we,      32'h0);
    check("rst_halted",  bus1.halted,  32'h0);
    check("rst_odata",   bus1.o_data,  32'h0);

    // JP 0000, LD A,5A / LD (8000),A / HALT
    hold_reset();
    load(16'h0100, 256'hC30000, 3);
    load(16'h0000, 256'h3E5A32008076, 6);
    poke(16'h8000, 8'h00);
    reset = 1'b0;
    run(14);
    check("st_count",  wr_count,       32'd1);
    check("st_addr",   wr_addr,        32'h8000);
    check("st_data",   wr_data,        32'h5A);
    check("st_mem",    mem[16'h8000],  32'h5A);
    check("halt_flag", bus1.halted,    32'h1);
    check("halt_addr", bus1.address,   32'h0006);
    check("halt_we",   bus1.we,        32'h0);

    // 16-bit load, INC/DEC, EXX and EX AF,AF' observed through stores
    hold_reset();
    load(16'h0100, 256'h21_34_12_23_2B_2B_D9_36_AA_D9_36_77_3E_5A_08_3E_11_32_00_80_08_32_01_80_76, 25);
    poke(16'h0000, 8'h00);
    poke(16'h1233, 8'h00);
    poke(16'h8000, 8'h00);
    poke(16'h8001, 8'h00);
    reset = 1'b0;
    run(35);
    check("exx_hl0",    mem[16'h0000], 32'hAA);
    check("incdec_hl",  mem[16'h1233], 32'h77);
    check("exaf_a",     mem[16'h8000], 32'h11);
    check("exaf_back",  mem[16'h8001], 32'h5A);
    check("regs_count", wr_count,      32'd4);
    check("regs_halt",  bus1.halted,   32'h1);
    check("regs_addr",  bus1.address,  32'h0119);

    // JR FE spins on itself
    hold_reset();
    load(16'h0100, 256'h18FE76, 3);
    reset = 1'b0;
    tick();
    check("jr_t2_addr", bus1.address, 32'h0101);
    check("jr_t2_m1",   bus1.m1,      32'h0);
    run(9);
    check("jr_loop_addr", bus1.address, 32'h0100);
    check("jr_loop_m1",   bus1.m1,      32'h1);
    check("jr_loop_halt", bus1.halted,  32'h0);

    // JR 02 skips LD A,99; JP 0200 then store A=00
    hold_reset();
    load(16'h0100, 256'h18023E99C30002, 7);
    load(16'h0200, 256'h32008076, 4);
    poke(16'h8000, 8'hFF);
    reset = 1'b0;
    run(14);
    check("jr_skip_mem",   mem[16'h8000], 32'h00);
    check("jr_skip_count", wr_count,      32'd1);
    check("jp_halt_addr",  bus1.address,  32'h0204);

    // Fetch at FFFF with operand wrapping to 0000
    hold_reset();
    load(16'h0100, 256'hC3FFFF, 3);
    poke(16'hFFFF, 8'h3E);
    load(16'h0000, 256'h4232008076, 5);
    poke(16'h8000, 8'hFF);
    reset = 1'b0;
    run(14);
    check("wrap_mem",  mem[16'h8000], 32'h42);
    check("wrap_addr", bus1.address,  32'h0005);

    // LD A,(8000) / LD (8001),A: write strobe during the 8th cycle
    hold_reset();
    load(16'h0100, 256'h3A008032018076, 7);
    poke(16'h8000, 8'hA5);
    poke(16'h8001, 8'h00);
    reset = 1'b0;
    run(7);
    check("cp_we",     bus1.we,       32'h1);
    check("cp_addr",   bus1.address,  32'h8001);
    check("cp_odata",  bus1.o_data,   32'hA5);
    check("cp_early",  wr_count,      32'd0);
    tick();
    check("cp_count",  wr_count,      32'd1);
    check("cp_mem",    mem[16'h8001], 32'hA5);
    check("cp_we_off", bus1.we,       32'h0);

    // Same copy with locked dropped while the strobe is pending
    hold_reset();
    poke(16'h8001, 8'h00);
    reset = 1'b0;
    run(7);
    locked = 1'b0;
    #1;
    check("lk_we_gated", bus1.we, 32'h0);
    run(3);
    check("lk_no_write", wr_count,     32'd0);
    check("lk_hold",     bus1.address, 32'h8001);
    locked = 1'b1;
    #1;
    check("lk_we_back",  bus1.we, 32'h1);
    tick();
    check("lk_count1",   wr_count, 32'd1);
    run(5);
    check("lk_count_end", wr_count,      32'd1);
    check("lk_mem",       mem[16'h8001], 32'hA5);
    check("lk_halt_addr", bus1.address,  32'h0107);
    check("lk_halted",    bus1.halted,   32'h1);

    // Reset during T3 of LD (nn),A aborts the store
    hold_reset();
    load(16'h0100, 256'h3E5A32008076, 6);
    reset = 1'b0;
    run(4);
    check("ab_pre_addr", bus1.address, 32'h0104);
    reset = 1'b1;
    tick();
    check("ab_we",      bus1.we,      32'h0);
    check("ab_addr",    bus1.address, 32'h0100);
    check("ab_m1",      bus1.m1,      32'h1);
    check("ab_count",   wr_count,     32'd0);
    reset = 1'b0;
    tick();
    check("ab_restart", bus1.address, 32'h0101);

    // HALT_EN=0: 76h is a plain 1T NOP
    reset2 = 1'b0;
    check("nh_rst_addr", bus2.address, 32'h0000);
    run(3);
    check("nh_addr",   bus2.address, 32'h0003);
    check("nh_halted", bus2.halted,  32'h0);
    check("nh_m1",     bus2.m1,      32'h1);
    check("nh_we",     bus2.we,      32'h0);
    check("nh_odata",  bus2.o_data,  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
